trng_ehr_collector: RTL and testbench
=====================================

# trng_ehr_collector

Entropy collection stage upstream of the TRNG register file. Samples the raw ring-oscillator bit at the programmed sample rate, optionally applies a von Neumann corrector, and shifts the resulting bits into the entropy holding register (EHR). When the EHR is full it pulses `ehr_valid` to the register file and holds the data for CPU/PRNG readout until the data is consumed or the logic is reset.

## Interface
Parameters:
- `SAMPLE_CNT_W`, 32, width of the sample-period counter and `sample_cnt1`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `rng_clk`  in  1  block clock.
- `rst`  in  1  asynchronous active-high reset.
- `rnd_bit_in`  in  1  raw asynchronous ring-oscillator output.
- `rnd_src_en`  in  1  collection enable.
- `sample_cnt1`  in  SAMPLE_CNT_W  sample period in `rng_clk` cycles.
- `vnc_bypass`  in  1  1 = skip the von Neumann corrector.
- `rst_trng_logic`  in  1  synchronous pulse: clear EHR and all counters.
- `ehr_rd_done`  in  1  pulse: EHR contents consumed (last word read by CPU or PRNG).
- `cpu_ehr_wr`  in  1  debug write strobe.
- `ehr_addr`  in  3  32-bit word index for read and debug write.
- `cpu_ehr_wdata`  in  32  debug write data.
- `ehr_rd_data`  out  32  EHR word selected by `ehr_addr` (combinational).
- `ehr_valid`  out  1  one-cycle pulse: EHR became full.
- `ehr_full`  out  1  level: EHR holds a complete sample.
- `ehr_bit_cnt`  out  8  bits collected so far.

## Operation
- N = 192 or 128 (see Configuration). W = N/32 words; word k = EHR[32k+31:32k]. `ehr_addr` ≥ W reads 0 and ignores writes.
- `rnd_bit_in` passes through a 2-flop synchronizer before sampling.
- States: IDLE, COLLECT, FULL. Reset → IDLE.
- IDLE: counters frozen, EHR retained. `rnd_src_en`=1 → COLLECT.
- COLLECT: the period counter loads P = max(`sample_cnt1`,1) and decrements each cycle. It issues a sample strobe when it reaches 1, then reloads P. `rnd_src_en`=0 → IDLE, with the partial state retained.
- Bypass: each strobe shifts the synchronized bit in, as `ehr <= {ehr[N-2:0], bit}`, and increments `ehr_bit_cnt`.
- Corrector: strobes pair up using a pair flag.
  - First strobe of a pair stores the bit.
  - Second strobe: if the two bits differ, the first bit is shifted in. If they are equal, nothing is shifted.
  - The pair flag toggles on every strobe.
- When `ehr_bit_cnt` reaches N → FULL, `ehr_full`=1, and `ehr_valid` pulses. No further sampling takes place.
- FULL: `ehr_rd_done` → clear the EHR and counters. The next state is COLLECT if `rnd_src_en`, otherwise IDLE.
- `rst_trng_logic`: the EHR, `ehr_bit_cnt`, the period counter and the pair flag are all cleared, and `ehr_full` is cleared. The next state is COLLECT if `rnd_src_en`, otherwise IDLE.
- `cpu_ehr_wr` writes the addressed word, in any state.
  - A write to word W-1 sets `ehr_full`=1, `ehr_bit_cnt`=N and state FULL.
  - A debug fill does **not** pulse `ehr_valid`; the register file sets trng_valid itself.
- Priority, highest first: `rst`, `rst_trng_logic`, `cpu_ehr_wr`, `ehr_rd_done`, sample shift.
- A strobe that coincides with `cpu_ehr_wr` is dropped, and the period counter still reloads.
- `vnc_bypass` changes take effect at the next strobe. The pair flag is not cleared by a bypass change.

## Timing
- Reset values: `ehr_rd_data`=0, `ehr_valid`=0, `ehr_full`=0, `ehr_bit_cnt`=0, EHR=0, state IDLE, pair flag=0, synchronizer=0.
- `rnd_bit_in` is reflected at the sampling point 2 cycles after it settles.
- First strobe: P cycles after entering COLLECT. Subsequent strobes: every P cycles.
- Nth bit shifted at edge t → `ehr_full` and the `ehr_valid` pulse are registered at edge t+1, high for exactly one cycle.
- `ehr_rd_data` is valid in the same cycle `ehr_addr` changes.
- `ehr_rd_done` at edge t → `ehr_full`=0 after edge t. Sampling restarts with a full period P.

## Configuration
- `TRNG_EHR_192_BITS_EN` defined: N=192, W=6, `ehr_addr` 0–5 valid.
- Not defined: N=128, W=4, `ehr_addr` 0–3 valid; addresses 4–5 read 0.

## Test plan
- Bypass mode, `sample_cnt1`=3, constant `rnd_bit_in`=1, `rnd_src_en`=1 → strobe every 3 cycles; after N strobes all words read 0xFFFFFFFF, `ehr_valid` is one pulse, and `ehr_full`=1.
- Corrector mode, alternating sample values 1,0,1,1,0,1 → only pairs (1,0) and (0,1) contribute, giving bits 1 then 0; `ehr_bit_cnt`=2.
- `sample_cnt1`=0 → behaves as P=1, with a strobe every cycle.
- `rst_trng_logic` pulsed at `ehr_bit_cnt`=70 → count returns to 0, EHR is 0, and collection restarts with `ehr_valid` not asserted.
- Debug writes of 0xA5A5A5A5 to words 0..W-1 → readback matches, `ehr_full`=1 after the write to word W-1, and `ehr_valid` stays 0.
- FULL plus `ehr_rd_done` with `rnd_src_en`=0 → state IDLE, EHR 0, and no strobes while disabled.

Source files
------------

// File: rtl/trng_ehr_collector.sv
// TRNG entropy collector: samples the ring-oscillator bit, optionally von Neumann corrects it, fills the EHR.
// Define TRNG_EHR_192_BITS_EN for a 192-bit EHR (six words); the default build uses 128 bits (four words).
//   state   | meaning
//   IDLE    | collection disabled, EHR and counts retained
//   COLLECT | period counter running, strobes shift bits into the EHR
//   FULL    | EHR complete, held until consumed
module trng_ehr_collector #(
  parameter int SAMPLE_CNT_W = 32
) (
  input  logic                    rng_clk,
  input  logic                    rst,
  input  logic                    rnd_bit_in,
  input  logic                    rnd_src_en,
  input  logic [SAMPLE_CNT_W-1:0] sample_cnt1,
  input  logic                    vnc_bypass,
  input  logic                    rst_trng_logic,
  input  logic                    ehr_rd_done,
  input  logic                    cpu_ehr_wr,
  input  logic [2:0]              ehr_addr,
  input  logic [31:0]             cpu_ehr_wdata,
  output logic [31:0]             ehr_rd_data,
  output logic                    ehr_valid,
  output logic                    ehr_full,
  output logic [7:0]              ehr_bit_cnt
);

`ifdef TRNG_EHR_192_BITS_EN
  localparam int N = 192;
`else
  localparam int N = 128;
`endif
  localparam int W = N / 32;

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t                  state, state_nx;
  logic [N-1:0]            ehr;
  logic [SAMPLE_CNT_W-1:0] per_cnt, per_load;
  logic                    sync1, sync2;
  logic                    pair_flag, first_bit;
  logic                    tick, clr_all, load_per, valid_nx;
  logic                    shift_en, shift_bit, cnt_done, wr_last;

  assign per_load  = (sample_cnt1 == '0) ? SAMPLE_CNT_W'(1) : sample_cnt1;
  assign cnt_done  = (ehr_bit_cnt == 8'(N));
  assign wr_last   = (ehr_addr == 3'(W-1));
  assign ehr_full  = (state == FULL);
  assign shift_en  = vnc_bypass ? 1'b1 : (pair_flag && (first_bit != sync2));
  assign shift_bit = vnc_bypass ? sync2 : first_bit;

  always_ff @(posedge rng_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tick     = 1'b0;
    clr_all  = 1'b0;
    load_per = 1'b0;
    valid_nx = 1'b0;
    case (state)
      IDLE: begin
        if (rnd_src_en) begin
          state_nx = COLLECT;
          load_per = 1'b1;
        end
      end
      COLLECT: begin
        if (cnt_done) begin
          state_nx = FULL;
          valid_nx = 1'b1;
        end else if (!rnd_src_en) begin
          state_nx = IDLE;
        end else if (per_cnt <= SAMPLE_CNT_W'(1)) begin
          tick     = 1'b1;
          load_per = 1'b1;
        end
      end
      FULL: begin
        if (ehr_rd_done) begin
          clr_all  = 1'b1;
          state_nx = rnd_src_en ? COLLECT : IDLE;
          load_per = rnd_src_en;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A debug write drops the strobe (the reload stays) and defers fill detection and readout.
    if (cpu_ehr_wr) begin
      tick     = 1'b0;
      valid_nx = 1'b0;
      clr_all  = 1'b0;
      if (state == FULL) begin
        state_nx = FULL;
        load_per = 1'b0;
      end
      if (state == COLLECT && state_nx == FULL) state_nx = COLLECT;
      if (wr_last) state_nx = FULL;
    end
    if (rst_trng_logic) begin
      tick     = 1'b0;
      valid_nx = 1'b0;
      clr_all  = 1'b1;
      state_nx = rnd_src_en ? COLLECT : IDLE;
      load_per = rnd_src_en;
    end
  end

  always_ff @(posedge rng_clk or posedge rst) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      ehr         <= '0;
      ehr_bit_cnt <= '0;
      per_cnt     <= '0;
      pair_flag   <= 1'b0;
      first_bit   <= 1'b0;
      ehr_valid   <= 1'b0;
    end else begin
      sync1     <= rnd_bit_in;
      sync2     <= sync1;
      ehr_valid <= valid_nx;
      if (clr_all) begin
        ehr         <= '0;
        ehr_bit_cnt <= '0;
        pair_flag   <= 1'b0;
        first_bit   <= 1'b0;
      end else begin
        if (cpu_ehr_wr) begin
          for (int k = 0; k < W; k++) begin
            if (ehr_addr == 3'(k)) ehr[32*k +: 32] <= cpu_ehr_wdata;
          end
          if (wr_last) ehr_bit_cnt <= 8'(N);
        end
        if (tick) begin
          pair_flag <= ~pair_flag;
          if (!pair_flag) first_bit <= sync2;
          if (shift_en) begin
            ehr         <= {ehr[N-2:0], shift_bit};
            ehr_bit_cnt <= ehr_bit_cnt + 8'd1;
          end
        end
      end
      if (load_per)                             per_cnt <= per_load;
      else if (clr_all)                         per_cnt <= '0;
      else if (state == COLLECT && per_cnt != '0) per_cnt <= per_cnt - SAMPLE_CNT_W'(1);
    end
  end

  always_comb begin
    ehr_rd_data = '0;
    for (int k = 0; k < W; k++) begin
      if (ehr_addr == 3'(k)) ehr_rd_data = ehr[32*k +: 32];
    end
  end

endmodule

// File: tb/tb_trng_ehr_collector.sv
// Directed bench for trng_ehr_collector: bypass fill, corrector pairs, P=0, logic reset, debug fill, readout.
module tb_trng_ehr_collector;

`ifdef TRNG_EHR_192_BITS_EN
  localparam int N = 192;
`else
  localparam int N = 128;
`endif
  localparam int W = N / 32;

  logic        rng_clk = 1'b0;
  logic        rst;
  logic        rnd_bit_in;
  logic        rnd_src_en;
  logic [31:0] sample_cnt1;
  logic        vnc_bypass;
  logic        rst_trng_logic;
  logic        ehr_rd_done;
  logic        cpu_ehr_wr;
  logic [2:0]  ehr_addr;
  logic [31:0] cpu_ehr_wdata;
  logic [31:0] ehr_rd_data;
  logic        ehr_valid;
  logic        ehr_full;
  logic [7:0]  ehr_bit_cnt;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;

  trng_ehr_collector #(.SAMPLE_CNT_W(32)) dut (
    .rng_clk(rng_clk), .rst(rst), .rnd_bit_in(rnd_bit_in), .rnd_src_en(rnd_src_en),
    .sample_cnt1(sample_cnt1), .vnc_bypass(vnc_bypass), .rst_trng_logic(rst_trng_logic),
    .ehr_rd_done(ehr_rd_done), .cpu_ehr_wr(cpu_ehr_wr), .ehr_addr(ehr_addr),
    .cpu_ehr_wdata(cpu_ehr_wdata), .ehr_rd_data(ehr_rd_data), .ehr_valid(ehr_valid),
    .ehr_full(ehr_full), .ehr_bit_cnt(ehr_bit_cnt)
  );

  always #5 rng_clk = ~rng_clk;

  always @(posedge rng_clk) begin
    #1;
    if (ehr_valid) valid_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge rng_clk);
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    ehr_addr = 3'(a);
    #1;
    d = ehr_rd_data;
  endtask

  logic [31:0] d;
  int first_full;
  int v0;
  logic vn_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; rnd_bit_in = 1'b0; rnd_src_en = 1'b0; sample_cnt1 = 32'd3; vnc_bypass = 1'b1;
    rst_trng_logic = 1'b0; ehr_rd_done = 1'b0; cpu_ehr_wr = 1'b0; ehr_addr = 3'd0;
    cpu_ehr_wdata = 32'd0;
    cyc(2);
    check("rst_rd_data", ehr_rd_data, 32'd0);
    check("rst_valid", 32'(ehr_valid), 32'd0);
    check("rst_full", 32'(ehr_full), 32'd0);
    check("rst_bit_cnt", 32'(ehr_bit_cnt), 32'd0);
    rst = 1'b0;
    rnd_bit_in = 1'b1;
    cyc(3);

    // bypass, P=3, constant 1
    first_full = -1;
    v0 = valid_cnt;
    rnd_src_en = 1'b1;
    for (int c = 1; c <= 3*N + 10; c++) begin
      cyc(1);
      if (c == 3) check("byp_cnt_c3", 32'(ehr_bit_cnt), 32'd0);
      if (c == 4) check("byp_cnt_c4", 32'(ehr_bit_cnt), 32'd1);
      if (c == 7) check("byp_cnt_c7", 32'(ehr_bit_cnt), 32'd2);
      if (ehr_full && first_full < 0) first_full = c;
    end
    check("byp_full_time", 32'(first_full), 32'(3*N + 2));
    check("byp_valid_pulses", 32'(valid_cnt - v0), 32'd1);
    check("byp_full", 32'(ehr_full), 32'd1);
    check("byp_bit_cnt", 32'(ehr_bit_cnt), 32'(N));
    for (int k = 0; k < W; k++) begin
      rd(k, d);
      check("byp_word", d, 32'hFFFF_FFFF);
    end

    // readout done while disabled
    rnd_src_en = 1'b0;
    ehr_rd_done = 1'b1;
    cyc(1);
    ehr_rd_done = 1'b0;
    check("done_full", 32'(ehr_full), 32'd0);
    check("done_bit_cnt", 32'(ehr_bit_cnt), 32'd0);
    rd(0, d);
    check("done_word0", d, 32'd0);
    cyc(10);
    check("idle_no_strobe", 32'(ehr_bit_cnt), 32'd0);
    check("idle_full", 32'(ehr_full), 32'd0);

    // sample_cnt1=0 behaves as P=1
    sample_cnt1 = 32'd0;
    rnd_src_en = 1'b1;
    cyc(5);
    check("p1_bit_cnt", 32'(ehr_bit_cnt), 32'd4);
    rd(0, d);
    check("p1_word0", d, 32'h0000_000F);
    for (int i = 0; i < 200 && ehr_bit_cnt != 8'd70; i++) cyc(1);
    check("rtl_pre_cnt", 32'(ehr_bit_cnt), 32'd70);
    v0 = valid_cnt;
    rst_trng_logic = 1'b1;
    cyc(1);
    rst_trng_logic = 1'b0;
    check("rtl_bit_cnt", 32'(ehr_bit_cnt), 32'd0);
    rd(0, d);
    check("rtl_word0", d, 32'd0);
    rd(2, d);
    check("rtl_word2", d, 32'd0);
    check("rtl_full", 32'(ehr_full), 32'd0);
    cyc(1);
    check("rtl_restart1", 32'(ehr_bit_cnt), 32'd1);
    cyc(3);
    check("rtl_restart4", 32'(ehr_bit_cnt), 32'd4);
    check("rtl_no_valid", 32'(valid_cnt - v0), 32'd0);
    rnd_src_en = 1'b0;

    // von Neumann corrector, P=3, samples 1,0,1,1,0,1
    rst_trng_logic = 1'b1;
    cyc(1);
    rst_trng_logic = 1'b0;
    vnc_bypass = 1'b0;
    sample_cnt1 = 32'd3;
    rnd_bit_in = vn_seq[0];
    cyc(3);
    rnd_src_en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc(1);
      if (c > 1 && (c - 1) % 3 == 0 && (c - 1) / 3 < 6) rnd_bit_in = vn_seq[(c - 1) / 3];
      if (c == 7)  check("vnc_pair1", 32'(ehr_bit_cnt), 32'd1);
      if (c == 13) check("vnc_pair2_equal", 32'(ehr_bit_cnt), 32'd1);
    end
    rnd_src_en = 1'b0;
    check("vnc_bit_cnt", 32'(ehr_bit_cnt), 32'd2);
    rd(0, d);
    check("vnc_word0", d, 32'h0000_0002);

    // debug fill
    rst_trng_logic = 1'b1;
    cyc(1);
    rst_trng_logic = 1'b0;
    v0 = valid_cnt;
    for (int k = 0; k < W; k++) begin
      cpu_ehr_wr = 1'b1;
      ehr_addr = 3'(k);
      cpu_ehr_wdata = 32'hA5A5_A5A5;
      cyc(1);
      cpu_ehr_wr = 1'b0;
      if (k == 0) check("dbg_full_early", 32'(ehr_full), 32'd0);
    end
    check("dbg_full", 32'(ehr_full), 32'd1);
    check("dbg_bit_cnt", 32'(ehr_bit_cnt), 32'(N));
    for (int k = 0; k < W; k++) begin
      rd(k, d);
      check("dbg_word", d, 32'hA5A5_A5A5);
    end
    cpu_ehr_wr = 1'b1;
    ehr_addr = 3'(W);
    cpu_ehr_wdata = 32'h1234_5678;
    cyc(1);
    cpu_ehr_wr = 1'b0;
    rd(W, d);
    check("dbg_oob_read", d, 32'd0);
    rd(0, d);
    check("dbg_word0_kept", d, 32'hA5A5_A5A5);
    check("dbg_no_valid", 32'(valid_cnt - v0), 32'd0);
    ehr_rd_done = 1'b1;
    cyc(1);
    ehr_rd_done = 1'b0;
    check("dbg_done_full", 32'(ehr_full), 32'd0);
    rd(W - 1, d);
    check("dbg_done_word", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
